// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, even parity, stop.
// Emits one-cycle done/perr pulses and recovers from framing errors.
module serial_parity_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  output logic [DATA_W-1:0] out_byte,
  output logic              done,
  output logic              perr
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    DONE,
    WAIT
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = in ? IDLE : DATA;
      DATA:    state_n = (cnt == LAST) ? PARITY : DATA;
      PARITY:  state_n = STOP;
      STOP:    state_n = in ? DONE : WAIT;
      DONE:    state_n = in ? IDLE : DATA;
      WAIT:    state_n = in ? IDLE : WAIT;
      default: state_n = IDLE;
    endcase
  end

  // par folds in data and parity bits; it is 0 at STOP for a good frame
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      out_byte <= '0;
      done     <= 1'b0;
      perr     <= 1'b0;
    end else begin
      done <= 1'b0;
      perr <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          cnt <= '0;
          par <= 1'b0;
        end
        DATA: begin
          shreg[cnt] <= in;
          par        <= par ^ in;
          if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: par <= par ^ in;
        STOP: begin
          if (in) begin
            out_byte <= shreg;
            done     <= ~par;
            perr     <= par;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed testbench for serial_parity_rx with DATA_W=8.
// Each scenario task drives frames and checks outputs inline.
module tb_serial_parity_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in = 1'b1;
  logic [7:0] out_byte;
  logic       done;
  logic       perr;

  int checks = 0;
  int errors = 0;

  serial_parity_rx #(.DATA_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .in(in),
    .out_byte(out_byte),
    .done(done),
    .perr(perr)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic b);
    @(negedge clk);
    in = b;
    @(posedge clk);
    #1;
  endtask

  // counts pulses seen before the stop edge
  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s, output int spur);
    spur = 0;
    drive(1'b0);
    if (done || perr) spur++;
    for (int i = 0; i < 8; i++) begin
      drive(d[i]);
      if (done || perr) spur++;
    end
    drive(p);
    if (done || perr) spur++;
    drive(s);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || perr !== 1'b0 || out_byte !== 8'h00) begin
      $display("FAIL reset: done=%b perr=%b out=%h want 0 0 00",
               done, perr, out_byte);
      errors++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      drive(1'b1);
      if (done || perr || out_byte !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL idle: %0d bad cycles want 0", bad);
      errors++;
    end
  endtask

  task automatic test_good();
    int spur;
    send_frame(8'hA5, 1'b0, 1'b1, spur);
    checks++;
    if (spur != 0) begin
      $display("FAIL good_spur: %0d pulses want 0", spur);
      errors++;
    end
    checks++;
    if (done !== 1'b1 || perr !== 1'b0 || out_byte !== 8'hA5) begin
      $display("FAIL good: done=%b perr=%b out=%h want 1 0 a5",
               done, perr, out_byte);
      errors++;
    end
    drive(1'b1);
    checks++;
    if (done !== 1'b0 || perr !== 1'b0 || out_byte !== 8'hA5) begin
      $display("FAIL good_clear: done=%b perr=%b out=%h want 0 0 a5",
               done, perr, out_byte);
      errors++;
    end
  endtask

  task automatic test_parity_err();
    int spur;
    send_frame(8'h01, 1'b0, 1'b1, spur);
    checks++;
    if (spur != 0) begin
      $display("FAIL perr_spur: %0d pulses want 0", spur);
      errors++;
    end
    checks++;
    if (done !== 1'b0 || perr !== 1'b1 || out_byte !== 8'h01) begin
      $display("FAIL perr: done=%b perr=%b out=%h want 0 1 01",
               done, perr, out_byte);
      errors++;
    end
    drive(1'b1);
    checks++;
    if (done !== 1'b0 || perr !== 1'b0) begin
      $display("FAIL perr_clear: done=%b perr=%b want 0 0", done, perr);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    int  spur;
    time t1;
    time t2;
    send_frame(8'h3C, 1'b0, 1'b1, spur);
    t1 = $time;
    checks++;
    if (done !== 1'b1 || out_byte !== 8'h3C || spur != 0) begin
      $display("FAIL b2b_first: done=%b out=%h spur=%0d want 1 3c 0",
               done, out_byte, spur);
      errors++;
    end
    send_frame(8'hFF, 1'b0, 1'b1, spur);
    t2 = $time;
    checks++;
    if (done !== 1'b1 || out_byte !== 8'hFF || spur != 0) begin
      $display("FAIL b2b_second: done=%b out=%h spur=%0d want 1 ff 0",
               done, out_byte, spur);
      errors++;
    end
    checks++;
    if ((t2 - t1) != 110) begin
      $display("FAIL b2b_spacing: %0t want 110", t2 - t1);
      errors++;
    end
    drive(1'b1);
  endtask

  task automatic test_framing();
    int spur;
    int bad;
    send_frame(8'h55, 1'b0, 1'b0, spur);
    checks++;
    if (spur != 0 || done !== 1'b0 || perr !== 1'b0 ||
        out_byte !== 8'hFF) begin
      $display("FAIL frm_stop: done=%b perr=%b out=%h spur=%0d want 0 0 ff 0",
               done, perr, out_byte, spur);
      errors++;
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0);
      if (done || perr || out_byte !== 8'hFF) bad++;
    end
    drive(1'b1);
    if (done || perr || out_byte !== 8'hFF) bad++;
    checks++;
    if (bad != 0) begin
      $display("FAIL frm_wait: %0d bad cycles want 0", bad);
      errors++;
    end
    send_frame(8'h81, 1'b0, 1'b1, spur);
    checks++;
    if (done !== 1'b1 || perr !== 1'b0 || out_byte !== 8'h81 || spur != 0) begin
      $display("FAIL frm_recover: done=%b perr=%b out=%h spur=%0d want 1 0 81 0",
               done, perr, out_byte, spur);
      errors++;
    end
    drive(1'b1);
  endtask

  task automatic test_reset_mid();
    int spur;
    int bad;
    logic [7:0] d;
    d = 8'h6B;
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(d[i]);
    @(negedge clk);
    reset = 1'b1;
    in = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || perr !== 1'b0 || out_byte !== 8'h00) begin
      $display("FAIL rst_mid: done=%b perr=%b out=%h want 0 0 00",
               done, perr, out_byte);
      errors++;
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1);
      if (done || perr || out_byte !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL rst_tail: %0d bad cycles want 0", bad);
      errors++;
    end
    send_frame(8'h12, 1'b0, 1'b1, spur);
    checks++;
    if (done !== 1'b1 || perr !== 1'b0 || out_byte !== 8'h12 || spur != 0) begin
      $display("FAIL rst_next: done=%b perr=%b out=%h spur=%0d want 1 0 12 0",
               done, perr, out_byte, spur);
      errors++;
    end
    drive(1'b1);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_good();
    test_parity_err();
    test_back_to_back();
    test_framing();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
- Serial frame receiver with even-parity checking.
- Sits upstream of the byte-level consumers and beside the parity generator. It deserialises a 1-bit line into a DATA_W-bit word, recomputes the even-parity bit, and compares it against the received one.
- Reports good frames and parity failures as one-cycle pulses.
- Detects framing errors (bad stop bit) and recovers from them.

Parameters:
- DATA_W, 8, number of data bits per frame (LSB first); legal range 2..16.

Ports:
- clk  input  1  rising-edge clock; one line bit is sampled per cycle.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge.
- in  input  1  serial line; idles at 1.
- out_byte  output  DATA_W  last deserialised word; meaningful when done or perr is high.
- done  output  1  one-cycle pulse: frame received with correct stop bit and correct even parity.
- perr  output  1  one-cycle pulse: frame received with correct stop bit but parity mismatch.

Behaviour:
- Frame format: start bit (0), DATA_W data bits LSB first, 1 parity bit, stop bit (1).
  - Even parity: the received parity bit must equal the XOR of all data bits.
  - Equivalently, the XOR of the data bits and the parity bit must be 0.
- Reset values: state=IDLE, bit counter=0, data shift register=0, out_byte=0, done=0, perr=0.
- FSM states and transitions (evaluated every rising edge):
  - IDLE: in=0 -> DATA (start bit consumed, counter=0); in=1 -> IDLE.
  - DATA: shift in into bit position [counter] and update the running parity.
    - counter==DATA_W-1 -> PARITY; otherwise counter+1 and stay in DATA.
  - PARITY: capture in as the received parity bit -> STOP.
  - STOP: in=1 -> DONE; in=0 -> WAIT (framing error, no pulse).
  - DONE (lasts exactly one cycle): done=1 if parity ok, else perr=1.
    - in=0 -> DATA (back-to-back start bit accepted, counter=0); in=1 -> IDLE.
  - WAIT: in=1 -> IDLE; in=0 -> WAIT.
    - The line must return high before a new start bit is recognised; the 1 sampled on exit is not a start bit.
- Outputs:
  - done and perr are registered, decoded from state DONE, and mutually exclusive.
  - Both are 0 in every state other than DONE.
  - out_byte updates only on entry to DONE and holds its value until the next frame reaches DONE.
  - A framing error does not update out_byte.
  - A parity error still updates out_byte.
- Latency: if the start bit is sampled at edge E0, data is sampled at E1..E_DATA_W, parity at E_DATA_W+1, and stop at E_DATA_W+2.
  - done/perr are high for the cycle following E_DATA_W+2 (for DATA_W=8: after E10, cleared at E11).
- Minimum frame spacing: DATA_W+3 cycles back-to-back (the start bit of the next frame can be sampled in the DONE cycle).
- Reset mid-frame: any state -> IDLE at the next edge; the partial frame is discarded and no pulse is produced. Reset has priority over all transitions.
- Bit counter width: clog2(DATA_W) bits; it never wraps past DATA_W-1.

Test Plan:
- Good frame, in=0, then A5 LSB-first (1,0,1,0,0,1,0,1), parity 0, stop 1 -> done=1 for exactly one cycle after the stop edge; out_byte=8'hA5; perr=0.
- Parity error, 0x01 frame with parity bit 0 (expected 1), stop 1 -> perr=1 for one cycle; done=0; out_byte=8'h01.
- Back-to-back frames 0x3C (parity 0) then 0xFF (parity 0), second start bit sampled in the DONE cycle -> two done pulses exactly 11 cycles apart; out_byte=3C, then FF.
- Framing error, 0x55 frame with stop bit 0, line held 0 for 5 more cycles, then 1, then a good 0x81 frame (parity 0) -> no pulse and out_byte unchanged during the bad frame; done=1 with out_byte=8'h81 for the recovered frame.
- Reset mid-frame, reset asserted after 4 data bits of a frame -> at the next edge done=perr=0 and out_byte=0; remaining bits with in=1 are ignored; the next complete 0x12 frame (parity 0) -> done=1, out_byte=8'h12.
- Idle line, in=1 for 50 cycles after reset -> done=perr=0 throughout; out_byte=0.
